roi_pixel_fetch: RTL and testbench
==================================

Name: roi_pixel_fetch

Overview:
- Responder for the tracker's window-read interface.
- Accepts row-fetch commands (cmd_wr with addr_length) from the meanshift/camshift iteration logic.
- Reads the addressed hue pixels from frame memory through a simple request/response port.
- Buffers the pixels in a show-ahead data FIFO that the tracker drains with data_rd, using almost_empty/almost_full for flow control.

Parameters:
- DEPTH, 64, data FIFO depth in pixels; power of two, at least 8.
- AE_THR, 4, almost_empty asserted when fill count <= AE_THR.
- AF_THR, 8, almost_full asserted when free slots <= AF_THR.
- MAX_OUT, 8, maximum outstanding memory reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_wr  in  1  command strobe; one command per high cycle.
- addr_length  in  33  [32:11] start pixel address; [10:0] pixel count.
- cmd_full  out  1  command queue full; cmd_wr is ignored while high.
- data_rd  in  1  pop the FIFO head.
- h_value  out  8  FIFO head pixel (show-ahead).
- almost_empty  out  1  fill count <= AE_THR.
- almost_full  out  1  DEPTH - fill count <= AF_THR.
- mem_req  out  1  memory read request.
- mem_addr  out  22  memory pixel address.
- mem_ack  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; responses return in order.
- mem_rdata  in  8  read pixel.
- busy  out  1  a command is active or reads are outstanding.

Behaviour:
- Reset (synchronous, active-high):
  - All queues and counters are cleared.
  - mem_req=0, mem_addr=0, h_value=0, cmd_full=0, almost_empty=1, almost_full=0, busy=0.
  - Reset mid-burst discards queued commands, FIFO contents and the outstanding count. mem_rvalid responses arriving after reset are dropped until a new command issues.
- Command queue:
  - Two-entry FIFO. cmd_full=1 when 2 entries are held.
  - cmd_wr while cmd_full is dropped; a bench assertion flags it.
  - A command with count 0 is accepted and retired without any memory access.
- Fetch FSM states: IDLE, LOAD, ISSUE, WAIT_DRAIN.
  - IDLE: if the queue is non-empty, go to LOAD.
  - LOAD (1 cycle): pop the command; cur_addr <= start; remain <= count. If count=0, return to IDLE; otherwise go to ISSUE.
  - ISSUE: mem_req=1 while credit is available, where credit = (fill + outstanding < DEPTH) and (outstanding < MAX_OUT).
    - mem_req drops in the same cycle credit is lost.
    - On mem_ack: cur_addr+1, remain-1, outstanding+1.
    - mem_addr holds stable while mem_req=1 and mem_ack=0.
    - The acked request that makes remain=0 moves the FSM to WAIT_DRAIN.
  - WAIT_DRAIN: stay until outstanding=0, then go to IDLE. The next command may load only after this, so commands never interleave.
- Address: 22-bit increment wraps from 0x3FFFFF to 0x000000 with no error.
- Outstanding counter:
  - +1 on mem_ack, -1 on mem_rvalid.
  - Both events in the same cycle leave the count unchanged.
- Data FIFO:
  - Each mem_rvalid writes mem_rdata. Credit accounting guarantees no overflow; an overflow is a design error and has a bench assertion.
  - data_rd pops the head when fill>0. data_rd on an empty FIFO is ignored and h_value holds.
  - h_value shows the new head the cycle after a pop. The first pixel appears 1 cycle after its mem_rvalid.
  - Simultaneous write and pop leave fill unchanged.
  - Pointers wrap modulo DEPTH.
- Flags: almost_empty and almost_full are registered from the next-state fill count, so they are valid in the same cycle as the fill count.
- busy = (state != IDLE) or (queue non-empty) or (outstanding != 0).

Test Plan:
- Single command, start=0x000100, count=16, mem_ack tied high, rvalid 3 cycles after ack, data_rd held high from first data:
  - 16 requests at addresses 0x100–0x10F.
  - h_value sequence matches memory model.
  - busy falls after the last pop.
- Backpressure: count=100, data_rd=0, DEPTH=64:
  - Requests stop with fill+outstanding=64.
  - almost_full=1 at fill>=56.
  - Pulsing data_rd resumes requests; all 100 pixels arrive in order.
- MAX_OUT limit: memory latency 20 cycles:
  - Outstanding never exceeds 8.
  - mem_addr stable whenever mem_req=1 and mem_ack=0.
- Queue and wrap:
  - Three back-to-back cmd_wr: cmd_full asserts after two; the third is dropped.
  - start=0x3FFFFE, count=4 gives addresses 3FFFFE, 3FFFFF, 000000, 000001.
- Zero length then reset:
  - Command count=0: no mem_req, and the FSM is back in IDLE within 2 cycles.
  - Then rst asserted mid-burst: all outputs at reset values next cycle and late rvalids ignored. A fresh command count=5 completes with 5 correct pixels.

Source files
------------

// File: rtl/roi_pixel_fetch.sv
// Window-read responder: queues row-fetch commands, streams the addressed hue
// pixels from frame memory into a show-ahead FIFO drained by the tracker.
module roi_pixel_fetch #(
  parameter int DEPTH   = 64,
  parameter int AE_THR  = 4,
  parameter int AF_THR  = 8,
  parameter int MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_wr,
  input  logic [32:0] addr_length,
  output logic        cmd_full,
  input  logic        data_rd,
  output logic [7:0]  h_value,
  output logic        almost_empty,
  output logic        almost_full,
  output logic        mem_req,
  output logic [21:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [21:0] start;
    logic [10:0] len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT_DRAIN} state_t;

  state_t          state;
  logic [21:0]     cur_addr;
  logic [10:0]     remain;
  logic [OW-1:0]   outs;
  logic [FW-1:0]   fill;

  // ---------------- command queue (2 entries) ----------------
  cmd_t        cq [2];
  logic        cq_wp, cq_rp;
  logic [1:0]  cq_cnt;
  logic        cq_push, cq_pop;
  cmd_t        cmd_head;

  assign cmd_full = (cq_cnt == 2'd2);
  assign cq_push  = cmd_wr && !cmd_full;
  assign cq_pop   = (state == LOAD);
  assign cmd_head = cq[cq_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_wp  <= 1'b0;
      cq_rp  <= 1'b0;
      cq_cnt <= 2'd0;
    end else begin
      if (cq_push) begin
        cq[cq_wp] <= cmd_t'(addr_length);
        cq_wp     <= ~cq_wp;
      end
      if (cq_pop) cq_rp <= ~cq_rp;
      cq_cnt <= cq_cnt + {1'b0, cq_push} - {1'b0, cq_pop};
    end
  end

  // ---------------- credit and request ----------------
  logic          rv_acc, ack_hs, credit;
  logic [FW:0]   inflight;

  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign rv_acc   = mem_rvalid && (outs != '0);
  assign ack_hs   = mem_req && mem_ack;
  assign inflight = {1'b0, fill} + (FW+1)'(outs);
  assign credit   = (inflight < (FW+1)'(DEPTH)) && (outs < OW'(MAX_OUT));
  assign mem_req  = (state == ISSUE) && credit;
  assign mem_addr = cur_addr;
  assign busy     = (state != IDLE) || (cq_cnt != 2'd0) || (outs != '0);

  // ---------------- fetch FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
    end else begin
      case (state)
        IDLE: if (cq_cnt != 2'd0) state <= LOAD;
        LOAD: begin
          cur_addr <= cmd_head.start;
          remain   <= cmd_head.len;
          state    <= (cmd_head.len == '0) ? IDLE : ISSUE;
        end
        ISSUE: if (ack_hs) begin
          cur_addr <= cur_addr + 22'd1;
          remain   <= remain - 11'd1;
          if (remain == 11'd1) state <= WAIT_DRAIN;
        end
        WAIT_DRAIN: if (outs == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) outs <= '0;
    else     outs <= outs + OW'(ack_hs) - OW'(rv_acc);
  end

  // ---------------- show-ahead data FIFO ----------------
  logic [7:0]    pix_mem [DEPTH];
  logic [PW-1:0] wp, rp, rp_nx;
  logic          pop;
  logic [FW-1:0] fill_nx, fill_left;
  logic [7:0]    h_nx;

  assign pop       = data_rd && (fill != '0);
  assign fill_left = fill - FW'(pop);
  assign fill_nx   = fill_left + FW'(rv_acc);
  assign rp_nx     = rp + PW'(pop);
  // When the FIFO would otherwise be empty, the incoming word becomes the head.
  assign h_nx      = (fill_left == '0) ? mem_rdata : pix_mem[rp_nx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      fill         <= '0;
      h_value      <= 8'd0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (rv_acc) begin
        pix_mem[wp] <= mem_rdata;
        wp          <= wp + PW'(1);
      end
      rp           <= rp_nx;
      fill         <= fill_nx;
      if (fill_nx != '0) h_value <= h_nx;
      almost_empty <= (fill_nx <= FW'(AE_THR));
      almost_full  <= ((FW'(DEPTH) - fill_nx) <= FW'(AF_THR));
    end
  end

endmodule

// File: tb/tb_roi_pixel_fetch.sv
// Bench for roi_pixel_fetch: memory responder with latency, address and pixel
// scoreboards, table of fetch commands plus queue/zero-length/reset sequences.
module tb_roi_pixel_fetch;
  localparam int DEPTH   = 64;
  localparam int MAX_OUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_wr = 1'b0;
  logic [32:0] addr_length = '0;
  logic        cmd_full;
  logic        data_rd = 1'b0;
  logic [7:0]  h_value;
  logic        almost_empty, almost_full;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        busy;

  roi_pixel_fetch #(.DEPTH(DEPTH), .AE_THR(4), .AF_THR(8), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .addr_length(addr_length),
    .cmd_full(cmd_full), .data_rd(data_rd), .h_value(h_value),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  typedef struct { int due; logic [7:0] data; int gen; } resp_t;
  typedef struct {
    logic [21:0] start;
    logic [10:0] cnt;
    int          lat;
    bit          ack_rand;
    bit          stall;
    int          exp_max;
  } vec_t;

  resp_t       rq[$];
  resp_t       r;
  logic [7:0]  sb[$];
  logic [21:0] ea[$];
  int          cyc = 0, gen = 0, fill_m = 0, outs_m = 0, max_outs = 0;
  int          acks = 0, pops = 0, lat = 3;
  bit          ack_rand = 1'b0, cons_en = 1'b1, cons_pulse = 1'b0;
  bit          prev_wait = 1'b0;
  logic [21:0] prev_addr = '0;

  // Memory model, consumer and per-cycle protocol checks, all at negedge.
  always @(negedge clk) begin
    cyc++;
    mem_rvalid = 1'b0;
    data_rd    = 1'b0;
    if (rst) begin
      gen++;
      fill_m = 0; outs_m = 0; prev_wait = 1'b0; mem_ack = 1'b0;
      sb.delete(); ea.delete();
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        mem_rvalid = 1'b1; mem_rdata = r.data;
      end
    end else begin
      chk("almost_empty", 32'(almost_empty), 32'(fill_m <= 4));
      chk("almost_full", 32'(almost_full), 32'((DEPTH - fill_m) <= 8));
      chk("fifo_overflow", 32'(fill_m + outs_m <= DEPTH), 32'd1);
      if (prev_wait) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      if (mem_req) chk("req_credit", 32'((fill_m + outs_m < DEPTH) && (outs_m < MAX_OUT)), 32'd1);
      if (cons_en && fill_m > 0 && (!cons_pulse || (cyc % 2 == 0))) begin
        chk("h_value", 32'(h_value), 32'(sb.pop_front()));
        data_rd = 1'b1;
        fill_m--; pops++;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        mem_rvalid = 1'b1; mem_rdata = r.data;
        if (r.gen == gen) begin outs_m--; fill_m++; end
      end
      mem_ack   = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (mem_req && mem_ack) begin
        acks++;
        if (ea.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(ea.pop_front()));
        end
        rq.push_back('{cyc + lat, pix(mem_addr), gen});
        sb.push_back(pix(mem_addr));
        outs_m++;
        if (outs_m > max_outs) max_outs = outs_m;
      end
    end
  end

  task automatic send_cmd(input logic [21:0] s, input logic [10:0] n, input bit exp_full);
    @(posedge clk); #1;
    chk("cmd_full", 32'(cmd_full), 32'(exp_full));
    if (!cmd_full)
      for (int i = 0; i < int'(n); i++) ea.push_back(s + 22'(i));
    cmd_wr = 1'b1;
    addr_length = {s, n};
  endtask

  task automatic end_cmd();
    @(posedge clk); #1;
    cmd_wr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 5000), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_addr_left"}, 32'(ea.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_h_value"}, 32'(h_value), 32'd0);
    chk({nm, "_cmd_full"}, 32'(cmd_full), 32'd0);
    chk({nm, "_almost_empty"}, 32'(almost_empty), 32'd1);
    chk({nm, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[5];
  int   n;

  initial begin
    vt[0] = '{22'h000100, 11'd16,  3,  1'b0, 1'b0, 3};
    vt[1] = '{22'h002000, 11'd100, 3,  1'b0, 1'b1, 3};
    vt[2] = '{22'h000040, 11'd30,  20, 1'b1, 1'b0, 8};
    vt[3] = '{22'h3FFFFE, 11'd4,   5,  1'b0, 1'b0, 4};
    vt[4] = '{22'h001FF0, 11'd8,   1,  1'b1, 1'b0, 1};

    repeat (3) @(posedge clk); #1;
    chk_reset_outs("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      lat = vt[v].lat; ack_rand = vt[v].ack_rand;
      cons_en = !vt[v].stall; cons_pulse = 1'b0;
      max_outs = 0; acks = 0; pops = 0;
      send_cmd(vt[v].start, vt[v].cnt, 1'b0);
      end_cmd();
      if (vt[v].stall) begin
        n = 0;
        while (fill_m < DEPTH && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (10) @(posedge clk);
        #1;
        chk("bp_acks", acks, DEPTH);
        chk("bp_req", 32'(mem_req), 32'd0);
        chk("bp_almost_full", 32'(almost_full), 32'd1);
        chk("bp_almost_empty", 32'(almost_empty), 32'd0);
        cons_en = 1'b1; cons_pulse = 1'b1;
      end
      wait_done("vec");
      chk("vec_acks", acks, 32'(vt[v].cnt));
      chk("vec_pops", pops, 32'(vt[v].cnt));
      chk("vec_max_out", max_outs, vt[v].exp_max);
      chk("vec_ae_end", 32'(almost_empty), 32'd1);
    end

    // Three back-to-back commands: the third meets a full queue.
    lat = 3; ack_rand = 1'b0; cons_en = 1'b1; cons_pulse = 1'b0; acks = 0; pops = 0;
    send_cmd(22'h000500, 11'd3, 1'b0);
    send_cmd(22'h000600, 11'd3, 1'b0);
    send_cmd(22'h000700, 11'd3, 1'b1);
    end_cmd();
    wait_done("queue");
    chk("queue_acks", acks, 6);
    chk("queue_pops", pops, 6);

    // Zero-length command retires without memory traffic.
    acks = 0;
    send_cmd(22'h000123, 11'd0, 1'b0);
    end_cmd();
    chk("zero_busy_q", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("zero_busy_load", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("zero_busy_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_acks", acks, 0);

    // Reset in the middle of a long-latency burst.
    lat = 10; acks = 0; pops = 0;
    send_cmd(22'h000800, 11'd40, 1'b0);
    end_cmd();
    repeat (15) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outs("midrst");
    repeat (20) @(posedge clk);
    #1;
    chk("stale_h_value", 32'(h_value), 32'd0);
    chk("stale_almost_empty", 32'(almost_empty), 32'd1);
    chk("stale_busy", 32'(busy), 32'd0);
    acks = 0; pops = 0;
    send_cmd(22'h000900, 11'd5, 1'b0);
    end_cmd();
    wait_done("post_rst");
    chk("post_rst_acks", acks, 5);
    chk("post_rst_pops", pops, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
